cordic_engine: RTL and testbench
================================

Name: cordic_engine

Overview:
- Parametrised iterative CORDIC core; next generation of the team's rotation-only CORDIC.
- Supports rotation and vectoring modes and full-circle input range via quadrant pre-rotation.
- Uses valid/ready handshakes, applies gain compensation with rounding and output saturation.
- Feeds the Givens-rotation / QR stage of the matrix-inversion datapath.

Parameters:
- STG, 12, number of micro-rotations (1..FRAC)
- SIZE, 16, width of x/y/z ports, signed two's complement
- FRAC, 12, fractional bits of all ports; SIZE-FRAC-1 integer bits, so 1.0 = 2^FRAC
- GUARD, 2, extra MSBs on internal x/y registers for CORDIC growth

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input operands valid
- in_ready  out  1  engine can accept operands
- mode  in  1  0 = rotation (drive z to 0), 1 = vectoring (drive y to 0); sampled on accept
- x_in  in  SIZE  signed x operand
- y_in  in  SIZE  signed y operand
- z_in  in  SIZE  signed angle in radians, range [-pi, pi]; ignored in vectoring mode
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  downstream accepts result
- x_out  out  SIZE  gain-compensated, saturated x
- y_out  out  SIZE  gain-compensated, saturated y
- z_out  out  SIZE  residual angle (rotation) / accumulated angle (vectoring)
- sat  out  1  x_out or y_out saturated in this result; valid with out_valid

Behaviour:
- Reset (async, any state including mid-operation):
  - state = IDLE, all data registers 0, out_valid = 0, sat = 0, in_ready = 1.
  - In-flight operation is discarded.
- Tables, fixed at elaboration:
  - ATAN[i] = round(atan(2^-i) * 2^FRAC). For FRAC=12: 3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2.
  - K = round(0.6072529350 * 2^FRAC) = 2487 for FRAC=12.
  - PI_2 = round(pi/2 * 2^FRAC) = 6434.
- FSM states: IDLE, ITER, SCALE, HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch mode, sign-extend x/y to SIZE+GUARD, apply pre-rotation, set counter i = 0, go to ITER.
- Pre-rotation, rotation mode:
  - z > PI_2: (x,y) = (-y,x), z -= PI_2.
  - z < -PI_2: (x,y) = (y,-x), z += PI_2.
  - Otherwise unchanged.
- Pre-rotation, vectoring mode:
  - z is always replaced; z_in is ignored.
  - x < 0 and y >= 0: (x,y) = (y,-x), z = PI_2.
  - x < 0 and y < 0: (x,y) = (-y,x), z = -PI_2.
  - Otherwise z = 0.
- ITER: one micro-rotation per cycle, using shifts x>>>i and y>>>i of the current registers.
  - Direction d = +1 if (rotation and z >= 0) or (vectoring and y < 0); else d = -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - After i = STG-1, go to SCALE.
- SCALE, one cycle:
  - xs = (x*K + 2^(FRAC-1)) >>> FRAC; ys likewise. Products are full width.
  - Saturate xs/ys to [-2^(SIZE-1), 2^(SIZE-1)-1]; sat = 1 if either clipped.
  - Register into x_out/y_out; z_out = z truncated to SIZE.
  - out_valid = 1, go to HOLD.
- HOLD:
  - Outputs stable, in_ready = 0.
  - When out_ready: out_valid drops next cycle, go to IDLE.
- Latency: accept cycle to out_valid high = STG+2 clocks. Throughput: one op per STG+3 cycles minimum.
- in_ready is 0 in ITER/SCALE/HOLD. in_valid in those states is ignored, not queued.
- out_ready while out_valid = 0 has no effect.
- Outputs keep their last result while in IDLE; only out_valid qualifies them.

Test Plan:
- Rotation, x=4096, y=0, z=3217 (pi/4) -> x_out,y_out = 2896 ±6 LSB; |z_out| <= 4; sat=0; out_valid exactly 14 cycles after accept (STG=12).
- Rotation, x=4096, y=0, z=9651 (3pi/4) -> pre-rotation path taken; x_out = -2896, y_out = 2896 ±6.
- Vectoring, x=3000, y=4000 -> x_out = 5000 ±6, |y_out| <= 6, z_out = 3798 ±4. Repeat with x=-4096, y=0 -> x_out = 4096, z_out = 12868 ±4.
- Vectoring, x=y=32767 -> x_out = 32767, sat=1, z_out = 3217 ±4.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs and out_valid stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> next cycle in_ready=1.
- Assert rst for 1 cycle mid-ITER -> outputs 0, out_valid=0, in_ready=1 immediately. Next operation completes normally with correct result.

Source files
------------

// File: rtl/cordic_engine.sv
// Iterative rotation/vectoring CORDIC with quadrant pre-rotation, rounded gain
// compensation and output saturation, behind valid/ready handshakes.
module cordic_engine #(
    parameter int STG   = 12,
    parameter int SIZE  = 16,
    parameter int FRAC  = 12,
    parameter int GUARD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            mode,
    input  logic [SIZE-1:0] x_in,
    input  logic [SIZE-1:0] y_in,
    input  logic [SIZE-1:0] z_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] x_out,
    output logic [SIZE-1:0] y_out,
    output logic [SIZE-1:0] z_out,
    output logic            sat
);
    localparam int W  = SIZE + GUARD;
    localparam int PW = W + FRAC + 2;
    localparam int CW = $clog2(STG + 1);

    // Constants held at 2^30 scale and rounded down to FRAC at elaboration.
    localparam longint K30  = 64'sd652032874;
    localparam longint P30  = 64'sd1686629713;
    localparam longint RND  = longint'(1) <<< (29 - FRAC);
    localparam longint K_L  = (K30 + RND) >>> (30 - FRAC);
    localparam longint P_L  = (P30 + RND) >>> (30 - FRAC);

    localparam logic signed [W-1:0]  PI2  = W'(P_L);
    localparam logic signed [PW-1:0] K_P  = PW'(K_L);
    localparam logic signed [PW-1:0] HALF = PW'(longint'(1) <<< (FRAC - 1));
    localparam logic signed [PW-1:0] MAXV = PW'((longint'(1) <<< (SIZE - 1)) - 1);
    localparam logic signed [PW-1:0] MINV = -MAXV - PW'(1);

    typedef enum logic [1:0] {IDLE, ITER, SCALE, HOLD} state_t;

    function automatic logic signed [W-1:0] atan_lut(input int idx);
        longint v;
        case (idx)
            0:  v = 64'sd843314857;
            1:  v = 64'sd497837829;
            2:  v = 64'sd263043836;
            3:  v = 64'sd133525158;
            4:  v = 64'sd67021686;
            5:  v = 64'sd33543515;
            6:  v = 64'sd16775850;
            7:  v = 64'sd8388437;
            8:  v = 64'sd4194282;
            9:  v = 64'sd2097149;
            10: v = 64'sd1048575;
            11: v = 64'sd524287;
            default: v = longint'(1) <<< (30 - idx);
        endcase
        v = (v + RND) >>> (30 - FRAC);
        return v[W-1:0];
    endfunction

    // Returns {clipped, value}: x*K rounded to nearest, then clamped to SIZE bits.
    function automatic logic [SIZE:0] scale_sat(input logic signed [W-1:0] v);
        logic signed [PW-1:0] p;
        p = $signed({{(PW-W){v[W-1]}}, v}) * K_P;
        p = (p + HALF) >>> FRAC;
        if (p > MAXV)      return {1'b1, MAXV[SIZE-1:0]};
        else if (p < MINV) return {1'b1, MINV[SIZE-1:0]};
        else               return {1'b0, p[SIZE-1:0]};
    endfunction

    state_t                state_q, state_d;
    logic signed [W-1:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CW-1:0]         i_q, i_d;
    logic                  mode_q, mode_d;
    logic [SIZE-1:0]       x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
    logic                  out_valid_q, out_valid_d, sat_q, sat_d;

    logic signed [W-1:0]   xe, ye, ze, xsh, ysh, atan_i;
    logic                  dpos;
    logic [SIZE:0]         xs, ys;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        mode_d      = mode_q;
        x_out_d     = x_out_q;
        y_out_d     = y_out_q;
        z_out_d     = z_out_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        xe     = {{GUARD{x_in[SIZE-1]}}, x_in};
        ye     = {{GUARD{y_in[SIZE-1]}}, y_in};
        ze     = {{GUARD{z_in[SIZE-1]}}, z_in};
        xsh    = x_q >>> i_q;
        ysh    = y_q >>> i_q;
        atan_i = atan_lut(int'(i_q));
        dpos   = mode_q ? y_q[W-1] : ~z_q[W-1];
        xs     = scale_sat(x_q);
        ys     = scale_sat(y_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mode_d  = mode;
                    i_d     = '0;
                    state_d = ITER;
                    x_d     = xe;
                    y_d     = ye;
                    if (!mode) begin
                        z_d = ze;
                        if (ze > PI2) begin
                            x_d = -ye;
                            y_d = xe;
                            z_d = ze - PI2;
                        end else if (ze < -PI2) begin
                            x_d = ye;
                            y_d = -xe;
                            z_d = ze + PI2;
                        end
                    end else begin
                        z_d = '0;
                        if (xe[W-1] && !ye[W-1]) begin
                            x_d = ye;
                            y_d = -xe;
                            z_d = PI2;
                        end else if (xe[W-1]) begin
                            x_d = -ye;
                            y_d = xe;
                            z_d = -PI2;
                        end
                    end
                end
            end
            ITER: begin
                if (dpos) begin
                    x_d = x_q - ysh;
                    y_d = y_q + xsh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + ysh;
                    y_d = y_q - xsh;
                    z_d = z_q + atan_i;
                end
                i_d = i_q + CW'(1);
                if (i_q == CW'(STG - 1)) state_d = SCALE;
            end
            SCALE: begin
                x_out_d     = xs[SIZE-1:0];
                y_out_d     = ys[SIZE-1:0];
                z_out_d     = z_q[SIZE-1:0];
                sat_d       = xs[SIZE] | ys[SIZE];
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            i_q         <= '0;
            mode_q      <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            mode_q      <= mode_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            z_out_q     <= z_out_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_cordic_engine.sv
// Directed-vector bench for cordic_engine: rotation/vectoring results, latency,
// backpressure and mid-operation reset.
module tb_cordic_engine;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               mode = 1'b0;
    logic signed [15:0] x_in = '0, y_in = '0, z_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] x_out, y_out, z_out;
    logic               sat;

    int n_chk  = 0;
    int n_fail = 0;
    int lat;

    always #5 clk = ~clk;

    cordic_engine #(.STG(12), .SIZE(16), .FRAC(12), .GUARD(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid),
        .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .z_out(z_out), .sat(sat)
    );

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        n_chk++;
        if (got - exp > tol || exp - got > tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Launch one operation and wait (bounded) for its result; lat counts edges
    // from the accept edge to the first edge after which out_valid is high.
    task automatic start_op(input logic m, input int x, input int y, input int z);
        @(negedge clk);
        mode = m; x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("op_done", int'(out_valid), 1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int x0, y0, z0;
        logic ok;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x", int'(x_out), 0);
        check("rst_sat", int'(sat), 0);
        rst = 1'b0;

        // rotate (1,0) by pi/4
        start_op(1'b0, 4096, 0, 3217);
        check("rot45_lat", lat, 14);
        check("rot45_x", int'(x_out), 2896, 6);
        check("rot45_y", int'(y_out), 2896, 6);
        check("rot45_z", int'(z_out), 0, 4);
        check("rot45_sat", int'(sat), 0);
        check("rot45_in_ready", int'(in_ready), 0);
        take_result();
        check("rot45_released", int'(out_valid), 0);

        // rotate by 3pi/4, exercises pre-rotation
        start_op(1'b0, 4096, 0, 9651);
        check("rot135_x", int'(x_out), -2896, 6);
        check("rot135_y", int'(y_out), 2896, 6);
        take_result();

        // rotate by -3pi/4
        start_op(1'b0, 4096, 0, -9651);
        check("rotm135_x", int'(x_out), -2896, 6);
        check("rotm135_y", int'(y_out), -2896, 6);
        take_result();

        // vector (3000,4000): magnitude 5000, angle 0.9273 rad
        start_op(1'b1, 3000, 4000, 1234);
        check("vec345_x", int'(x_out), 5000, 6);
        check("vec345_y", int'(y_out), 0, 6);
        check("vec345_z", int'(z_out), 3798, 4);
        take_result();

        // vector (-1,0): angle pi
        start_op(1'b1, -4096, 0, 0);
        check("vecneg_x", int'(x_out), 4096, 6);
        check("vecneg_z", int'(z_out), 12868, 4);
        take_result();

        // vector (-1,-1): angle -3pi/4
        start_op(1'b1, -4096, -4096, 0);
        check("vecq3_x", int'(x_out), 5793, 6);
        check("vecq3_z", int'(z_out), -9651, 4);
        take_result();

        // full-scale vector saturates magnitude
        start_op(1'b1, 32767, 32767, 0);
        check("vecsat_x", int'(x_out), 32767);
        check("vecsat_sat", int'(sat), 1);
        check("vecsat_z", int'(z_out), 3217, 4);
        x0 = int'(x_out); y0 = int'(y_out); z0 = int'(z_out);

        // backpressure: result held, new requests ignored
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            mode = 1'b0; x_in = 16'sd100; y_in = 16'sd0; z_in = 16'sd0;
            @(posedge clk);
            @(negedge clk);
            if (!out_valid || in_ready || !sat || int'(x_out) != x0 ||
                int'(y_out) != y0 || int'(z_out) != z0)
                ok = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_hold", int'(ok), 1);
        take_result();
        check("bp_in_ready", int'(in_ready), 1);
        check("bp_out_valid", int'(out_valid), 0);
        check("bp_keep_x", int'(x_out), x0);
        repeat (3) @(negedge clk);
        check("bp_not_queued", int'(in_ready), 1);

        // reset in the middle of ITER
        @(negedge clk);
        mode = 1'b0; x_in = 16'sd4096; y_in = 16'sd0; z_in = 16'sd3217;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_x", int'(x_out), 0);
        check("mid_rst_sat", int'(sat), 0);
        @(negedge clk);
        rst = 1'b0;

        start_op(1'b0, 4096, 0, 3217);
        check("post_rst_lat", lat, 14);
        check("post_rst_x", int'(x_out), 2896, 6);
        check("post_rst_y", int'(y_out), 2896, 6);
        take_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
